// File: rtl/i2d_ifq.sv
// i2d_ifq: instruction queue between the i2d fetch stage and decode.
// Latency: 1 cycle fetch-to-head (0 cycles with I2D_IFQ_BYPASS_EN defined and the queue empty).
// Backpressure: fetch_halt rises at DEPTH-1 entries or on flush; a word arriving while full with no pop is dropped and sets the sticky ovf.
//
// Ports:
//   clk, rst                       core clock, synchronous active-high reset
//   in_valid/in_ins/in_pc/in_err   fetched word, its PC and bus-error flag
//   flush                          PC redirect, discards every entry
//   fetch_halt                     stop issuing fetches
//   out_valid/out_ready            head handshake towards decode
//   out_ins/out_pc/out_err         head entry (NOP / 0 / 0 when out_valid=0)
//   ovf                            sticky overflow, cleared only by rst
//   count                          occupancy, 0..DEPTH
//
// Optional macro I2D_IFQ_BYPASS_EN: when defined, an empty queue forwards the
// incoming word to the head in the same cycle; if decode takes it right away
// it is never written.

`ifndef CORE_OPCODE_NOP
`define CORE_OPCODE_NOP 8'h15
`endif

module i2d_ifq #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [31:0]      in_ins,
    input  logic [31:0]      in_pc,
    input  logic             in_err,
    input  logic             flush,
    output logic             fetch_halt,
    output logic             out_valid,
    output logic [31:0]      out_ins,
    output logic [31:0]      out_pc,
    output logic             out_err,
    input  logic             out_ready,
    output logic             ovf,
    output logic [PTR_W:0]   count
);

    localparam logic [31:0] NOP_WORD =
        {`CORE_OPCODE_NOP, {(32 - $bits(`CORE_OPCODE_NOP)){1'b0}}};
    localparam logic [PTR_W:0] FULL_LVL = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0] HALT_LVL = (PTR_W + 1)'(DEPTH - 1);

    logic [31:0]      ins_mem [DEPTH];
    logic [31:0]      pc_mem  [DEPTH];
    logic             err_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   cnt_q;
    logic             ovf_q;

    logic             q_valid;
    logic             full;
    logic             q_pop;
    logic             push;
    logic             drop;
    logic             head_vld;
    logic [31:0]      head_ins;
    logic [31:0]      head_pc;
    logic             head_err;

    assign q_valid = (cnt_q != '0);
    assign full    = (cnt_q == FULL_LVL);
    // Only a stored entry advances rd_ptr; a bypassed word never occupies storage.
    assign q_pop   = q_valid & out_ready;
    assign drop    = in_valid & full & ~q_pop;

`ifdef I2D_IFQ_BYPASS_EN
    logic byp;
    logic byp_take;

    assign byp      = ~q_valid & in_valid & ~flush;
    assign byp_take = byp & out_ready;
    assign push     = in_valid & ~byp_take & (~full | q_pop);

    always_comb begin
        head_vld = q_valid | byp;
        head_ins = ins_mem[rd_ptr];
        head_pc  = pc_mem[rd_ptr];
        head_err = err_mem[rd_ptr];
        if (byp) begin
            head_ins = in_ins;
            head_pc  = in_pc;
            head_err = in_err;
        end
    end
`else
    assign push = in_valid & (~full | q_pop);

    always_comb begin
        head_vld = q_valid;
        head_ins = ins_mem[rd_ptr];
        head_pc  = pc_mem[rd_ptr];
        head_err = err_mem[rd_ptr];
    end
`endif

    // Storage is not reset; entries are only observable once count covers them.
    always_ff @(posedge clk) begin
        if (push & ~flush & ~rst) begin
            ins_mem[wr_ptr] <= in_ins;
            pc_mem[wr_ptr]  <= in_pc;
            err_mem[wr_ptr] <= in_err;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
        end else if (flush) begin
            // Redirect: same-cycle push is discarded, a same-cycle pop is moot.
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (q_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, q_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
            if (drop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // One slot of slack covers the fetch already in flight when halt rises.
    assign fetch_halt = (cnt_q >= HALT_LVL) | flush;

    assign out_valid = head_vld;
    assign out_ins   = head_vld ? head_ins : NOP_WORD;
    assign out_pc    = head_vld ? head_pc : 32'h0;
    assign out_err   = head_vld & head_err;
    assign ovf       = ovf_q;
    assign count     = cnt_q;

endmodule

// File: doc/i2d_ifq.md
Name: i2d_ifq

Overview:
- Instruction queue between the i2d fetch stage and the decode stage.
- Buffers fetched instruction/PC/error triples in a small FIFO and presents them to decode with a valid/ready handshake.
- Generates the fetch halt (back-pressure) and discards all buffered entries on a PC redirect (flush).
- Decouples bus-wait jitter on the fetch side from decode stalls.

Parameters:
- DEPTH, 4, number of queue entries; power of two, minimum 2.
- PTR_W, 2, pointer width; equals log2(DEPTH).

Ports:
- clk  in  1  core clock
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  fetch delivered a word this cycle (bus ack)
- in_ins  in  32  fetched instruction word
- in_pc  in  32  PC of the fetched word
- in_err  in  1  bus error on this fetch
- flush  in  1  PC redirect; discard all entries
- fetch_halt  out  1  to fetch stage halt input; stop issuing fetches
- out_valid  out  1  head entry valid
- out_ins  out  32  head instruction; NOP word when out_valid=0
- out_pc  out  32  head PC; 0 when out_valid=0
- out_err  out  1  head entry carries a bus error
- out_ready  in  1  decode accepts the head this cycle
- ovf  out  1  sticky overflow flag; a word arrived while the queue was full
- count  out  PTR_W+1  current occupancy, 0..DEPTH

Behaviour:
- Reset: when rst=1 at posedge, wr_ptr=0, rd_ptr=0, count=0, ovf=0. Outputs after reset: out_valid=0, out_ins=NOP, out_pc=0, out_err=0, fetch_halt=0. Storage contents are don't-care.
- NOP word = {`CORE_OPCODE_NOP, zero fill to 32 bits}.
- pop = out_valid & out_ready. push = in_valid & (count<DEPTH | pop).
- All state updates at posedge clk. count' = count + push - pop.
  - Simultaneous push and pop: count unchanged; both pointers advance.
- Pointers wrap modulo DEPTH by natural PTR_W-bit overflow.
- Read path: out_* driven combinationally from mem[rd_ptr], gated by out_valid = (count!=0).
- Push latency: a word pushed in cycle N is visible at the head no earlier than cycle N+1.
- fetch_halt = (count >= DEPTH-1) | flush. The -1 reserves one slot for the word already in flight when halt rises.
- Overflow: in_valid=1 while count==DEPTH and pop=0 → the word is dropped and ovf is set to 1. ovf clears only on rst.
- Flush (highest priority after rst):
  - Next state: count=0, wr_ptr=0, rd_ptr=0.
  - An in_valid in the same cycle is discarded.
  - A pop in the same cycle still counts as a handshake for decode, but has no effect on queue state.
  - ovf is unaffected.
- Error entries:
  - in_err is stored alongside its word.
  - The entry pops normally. out_err is 1 exactly while that entry is at the head.
  - The queue takes no further action; decode/exception logic decides what to do.
- Empty with out_ready=1: no pop, no state change.
- Full with pop and in_valid: push accepted; count stays DEPTH.
- rst asserted mid-operation overrides flush, push and pop. All entries are lost.

Optional Feature:
- Macro: I2D_IFQ_BYPASS_EN.
- Defined:
  - When count==0 and in_valid=1 and flush=0, out_valid=1 and out_ins/out_pc/out_err = in_ins/in_pc/in_err in the same cycle (zero-latency path).
  - If out_ready=1 in that cycle, the word is consumed and is not written (count stays 0).
  - If out_ready=0, the word is written normally.
- Not defined:
  - No combinational path from the in_* inputs to the out_* outputs.
  - Minimum latency is 1 cycle, as specified above.

Test Plan:
- Reset then idle → out_valid=0, out_ins=NOP, out_pc=0, fetch_halt=0, count=0, ovf=0.
- Push pc=0x0,0x4,0x8 (ins 0x11111111, 0x22222222, 0x33333333), out_ready=0 → count=3 and fetch_halt=1 at DEPTH=4. Then out_ready=1 → pops in order with pc 0x0, 0x4, 0x8; count returns to 0; fetch_halt drops once count<3.
- Fill 4 entries, then in_valid with pc=0x10 and out_ready=0 → word dropped, ovf=1 sticky, count=4. Next cycle in_valid pc=0x14 with out_ready=1 → head pc=0x0 pops, 0x14 is pushed, count stays 4.
- With 3 entries queued, assert flush for 1 cycle while in_valid carries pc=0x40 → next cycle count=0, out_valid=0. Push pc=0x100 → head pc=0x100 after 1 cycle.
- Push pc=0x8 with in_err=1 between two clean words → out_err=1 only while pc=0x8 is at the head.
- Pointer wrap: stream 10 words pc=0x0..0x24 with out_ready toggling 1,0,1,0… → outputs in exact order with no loss and no duplicates. With I2D_IFQ_BYPASS_EN, an empty queue with out_ready=1 presents pc=0x0 in the same cycle it arrives.
